// File: rtl/signed_calc_seq.sv
// Sequential shift-and-add evaluator of f = CA*a - CB*b with valid/ready on both sides.
// Define SIGNED_CALC_SEQ_PASS_EN to let DONE retire a result and accept new operands on the same edge.
module signed_calc_seq #(
   parameter int          DW = 5,
   parameter int          CW = 4,
   parameter int unsigned CA = 6,
   parameter int unsigned CB = 11
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [DW-1:0]        i_as,
   input  logic [DW-1:0]        i_bs,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [DW+CW:0]       o_fs,
   output logic                 o_busy
);

   localparam int RW = DW + CW + 1;
   localparam int NW = (CW > 1) ? $clog2(CW) : 1;
   localparam logic [CW-1:0] CA_BITS = CW'(CA);
   localparam logic [CW-1:0] CB_BITS = CW'(CB);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  w_load;
   logic signed [RW-1:0]  r_acc;
   logic signed [RW-1:0]  r_a;
   logic signed [RW-1:0]  r_b;
   logic        [RW-1:0]  r_fs;
   logic        [NW-1:0]  r_cnt;
   logic                  w_last;
   logic signed [RW-1:0]  w_term_a;
   logic signed [RW-1:0]  w_term_b;
   logic signed [RW-1:0]  w_acc_next;

   assign w_last     = (r_cnt == NW'(CW - 1));
   assign w_term_a   = CA_BITS[r_cnt] ? (r_a <<< r_cnt) : '0;
   assign w_term_b   = CB_BITS[r_cnt] ? (r_b <<< r_cnt) : '0;
   assign w_acc_next = r_acc + w_term_a - w_term_b;
   assign o_fs       = r_fs;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      o_ready      = 1'b0;
      o_valid      = 1'b0;
      o_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               w_load       = 1'b1;
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            o_busy = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            o_valid = 1'b1;
`ifdef SIGNED_CALC_SEQ_PASS_EN
            // Result retires and the next pair is taken on the same edge.
            o_ready = i_ready;
            if (i_ready) begin
               if (i_valid) begin
                  w_load       = 1'b1;
                  w_state_next = S_CALC;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
`else
            if (i_ready) begin
               w_state_next = S_IDLE;
            end
`endif
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_fs  <= '0;
         r_cnt <= '0;
      end else if (w_load) begin
         r_a   <= {{(CW+1){i_as[DW-1]}}, i_as};
         r_b   <= {{(CW+1){i_bs[DW-1]}}, i_bs};
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == S_CALC) begin
         r_acc <= w_acc_next;
         r_cnt <= r_cnt + NW'(1);
         // o_fs only moves when the final sum is known, so it holds through CALC.
         if (w_last) begin
            r_fs <= w_acc_next;
         end
      end
   end

endmodule

// File: tb/tb_signed_calc_seq.sv
// Directed and randomized checks of signed_calc_seq with default parameters (f = 6a - 11b).
module tb_signed_calc_seq;

   localparam int DW = 5;
   localparam int CW = 4;
   localparam int RW = DW + CW + 1;
   localparam int NRAND = 1000;
`ifdef SIGNED_CALC_SEQ_PASS_EN
   localparam int EXP_II = CW + 1;
`else
   localparam int EXP_II = CW + 2;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          i_ready;
   logic [DW-1:0] i_as;
   logic [DW-1:0] i_bs;
   logic          o_ready;
   logic          o_valid;
   logic          o_busy;
   logic [RW-1:0] o_fs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   signed_calc_seq dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_as    (i_as),
      .i_bs    (i_bs),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_fs    (o_fs),
      .o_busy  (o_busy)
   );

   // Drives one transaction with i_ready high; lat = edges from acceptance to o_valid, -1 on timeout.
   task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [RW-1:0] fs, output int lat);
      int guard;
      guard = 0;
      while (!o_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      i_as = a;
      i_bs = b;
      i_ready = 1'b1;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!o_valid) begin
         lat = -1;
         fs = 'x;
      end else begin
         fs = o_fs;
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_as = '0;
      i_bs = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
      n_cmp++;
      if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      n_cmp++;
      if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_cmp++;
      if (o_fs !== '0) begin n_bad++; $display("FAIL reset_fs: got %h want 0", o_fs); end
      rst = 1'b0;
      @(negedge clk);
      $display("reset: done");
   endtask

   task automatic test_basic;
      int lat;
      logic [RW-1:0] ev;
      ev = RW'(-4);
      i_as = 5'd3;
      i_bs = 5'd2;
      i_ready = 1'b1;
      i_valid = 1'b1;
      n_cmp++;
      if (o_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ready: got %b want 1", o_ready); end
      @(negedge clk);
      i_valid = 1'b0;
      n_cmp++;
      if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
         n_bad++; $display("FAIL basic_calc_flags: busy=%b ready=%b want busy=1 ready=0", o_busy, o_ready);
      end
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== CW) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, CW); end
      n_cmp++;
      if (o_fs !== ev) begin n_bad++; $display("FAIL basic_fs: got %0d want -4", $signed(o_fs)); end
      n_cmp++;
      if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_busy: got %b want 0", o_busy); end
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_width: got %b want 0", o_valid); end
      $display("txn basic a=3 b=2 fs=%0d lat=%0d", $signed(o_fs), lat);
   endtask

   task automatic test_extremes;
      logic [RW-1:0] fs;
      logic [RW-1:0] ev;
      int lat;
      ev = RW'(266);
      run_txn(5'd15, 5'b10000, fs, lat);
      n_cmp++;
      if (lat !== CW || fs !== ev) begin
         n_bad++; $display("FAIL max_result: got %h lat=%0d want %h lat=%0d", fs, lat, ev, CW);
      end
      $display("txn max a=15 b=-16 fs=%0d", $signed(fs));
      ev = RW'(-261);
      run_txn(5'b10000, 5'd15, fs, lat);
      n_cmp++;
      if (lat !== CW || fs !== ev) begin
         n_bad++; $display("FAIL min_result: got %h lat=%0d want %h lat=%0d", fs, lat, ev, CW);
      end
      $display("txn min a=-16 b=15 fs=%0d", $signed(fs));
   endtask

   task automatic test_stall;
      int guard;
      logic [RW-1:0] ev;
      ev = RW'(47);
      i_as = 5'b11011;
      i_bs = 5'b11001;
      i_ready = 1'b0;
      i_valid = 1'b1;
      @(negedge clk);
      guard = 0;
      while (!o_valid && guard < 40) begin
         i_as = ~i_as;
         i_valid = ~i_valid;
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (o_valid !== 1'b1 || o_fs !== ev) begin
         n_bad++; $display("FAIL stall_first: valid=%b fs=%0d want valid=1 fs=47", o_valid, $signed(o_fs));
      end
      for (int k = 0; k < 7; k++) begin
         i_as = ~i_as;
         i_bs = DW'(k);
         i_valid = ~i_valid;
         @(negedge clk);
         n_cmp++;
         if (o_valid !== 1'b1 || o_fs !== ev) begin
            n_bad++; $display("FAIL stall_hold%0d: valid=%b fs=%0d want valid=1 fs=47", k, o_valid, $signed(o_fs));
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 1'b0 || o_fs !== ev) begin
         n_bad++; $display("FAIL stall_release: valid=%b fs=%0d want valid=0 fs=47", o_valid, $signed(o_fs));
      end
      $display("txn stall a=-5 b=-7 fs=%0d", $signed(ev));
   endtask

   task automatic test_reset_mid;
      logic seen;
      logic [RW-1:0] fs;
      logic [RW-1:0] ev;
      int lat;
      i_as = 5'd7;
      i_bs = 5'd1;
      i_ready = 1'b1;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy: got %b want 1", o_busy); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_fs !== '0) begin
         n_bad++;
         $display("FAIL midrst_outputs: ready=%b valid=%b busy=%b fs=%h want 1 0 0 000",
                  o_ready, o_valid, o_busy, o_fs);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_valid: got %b want 0", seen); end
      ev = RW'(-5);
      run_txn(5'd1, 5'd1, fs, lat);
      n_cmp++;
      if (lat !== CW || fs !== ev) begin
         n_bad++; $display("FAIL midrst_next: got %0d lat=%0d want -5 lat=%0d", $signed(fs), lat, CW);
      end
      $display("txn after_reset a=1 b=1 fs=%0d", $signed(fs));
   endtask

   task automatic test_back_to_back;
      logic [RW-1:0] res [4];
      int rcyc [4];
      int acyc [4];
      int n;
      int m;
      logic [RW-1:0] ev;
      n = 0;
      m = 0;
      i_ready = 1'b1;
      i_bs = '0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         i_valid = (m < 4);
         i_as = DW'(m + 1);
         #1;
         if (o_valid && n < 4) begin
            res[n] = o_fs;
            rcyc[n] = cyc;
            n++;
         end
         if (o_ready && i_valid) begin
            acyc[m] = cyc;
            m++;
         end
         @(negedge clk);
      end
      i_valid = 1'b0;
      n_cmp++;
      if (n !== 4 || m !== 4) begin n_bad++; $display("FAIL stream_count: got %0d/%0d want 4/4", n, m); end
      for (int k = 0; k < 4; k++) begin
         ev = RW'(6 * (k + 1));
         n_cmp++;
         if (k >= n || res[k] !== ev) begin
            n_bad++; $display("FAIL stream_res%0d: got %0d want %0d", k, $signed(res[k]), 6 * (k + 1));
         end else begin
            $display("txn stream a=%0d b=0 fs=%0d", k + 1, $signed(res[k]));
         end
      end
      for (int k = 1; k < 4; k++) begin
         n_cmp++;
         if (k >= m || k >= n || acyc[k] - acyc[k-1] !== EXP_II || rcyc[k] - rcyc[k-1] !== EXP_II) begin
            n_bad++;
            $display("FAIL stream_ii%0d: accept gap=%0d result gap=%0d want %0d",
                     k, acyc[k] - acyc[k-1], rcyc[k] - rcyc[k-1], EXP_II);
         end
      end
   endtask

   task automatic test_random;
      logic [RW-1:0] q [$];
      logic [RW-1:0] ev;
      int sent;
      int rcvd;
      int cyc;
      int e;
      logic accepted;
      logic seen;
      sent = 0;
      rcvd = 0;
      cyc = 0;
      i_as = DW'($urandom);
      i_bs = DW'($urandom);
      i_valid = 1'b1;
      while (rcvd < NRAND && cyc < 30000) begin
         i_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (o_valid && i_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++; $display("FAIL rand_extra: got %0d with no result pending", $signed(o_fs));
            end else begin
               ev = q.pop_front();
               if (o_fs !== ev) begin
                  n_bad++; $display("FAIL rand_result%0d: got %0d want %0d", rcvd, $signed(o_fs), $signed(ev));
               end else begin
                  $display("txn rand %0d fs=%0d", rcvd, $signed(o_fs));
               end
            end
            rcvd++;
         end
         accepted = i_valid && o_ready;
         if (accepted) begin
            e = 6 * int'($signed(i_as)) - 11 * int'($signed(i_bs));
            q.push_back(RW'(e));
            sent++;
         end
         @(negedge clk);
         cyc++;
         if ((accepted || !i_valid) && sent < NRAND) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_as = DW'($urandom);
            i_bs = DW'($urandom);
         end else if (sent >= NRAND) begin
            i_valid = 1'b0;
         end
      end
      n_cmp++;
      if (rcvd !== NRAND || q.size() !== 0) begin
         n_bad++; $display("FAIL rand_total: got %0d results, %0d pending, want %0d/0", rcvd, q.size(), NRAND);
      end
      i_ready = 1'b1;
      i_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL rand_tail: got valid=%b want 0", seen); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/signed_calc_seq.md
# signed_calc_seq

Multi-cycle sequencer that computes the signed linear combination f = CA·a − CB·b using one shared adder. It walks the coefficient bits of CA and CB with shift-and-add, one bit per clock. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. Defaults (CA=6, CB=11, 5-bit operands) reproduce the team's 6X−11Y signed calculator result sequentially, in place of a combinational multiplier pair.

## Interface
- DW, 5: operand width, signed two's complement
- CW, 4: coefficient width, unsigned; also the number of CALC cycles
- CA, 6: coefficient applied to i_as, must be in 0..2^CW−1
- CB, 11: coefficient applied to i_bs, must be in 0..2^CW−1
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  operand pair offered
- o_ready  out  1  block can accept an operand pair this cycle
- i_as  in  DW  signed operand a
- i_bs  in  DW  signed operand b
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result this cycle
- o_fs  out  DW+CW+1  signed result CA·a − CB·b
- o_busy  out  1  high in CALC

## Operation
- States: IDLE, CALC, DONE.
- Reset: state=IDLE, acc=0, cnt=0, operand registers=0.
- Output reset values: o_ready=1, o_valid=0, o_busy=0, o_fs=0.
- IDLE:
  - o_ready=1.
  - When i_valid=1: latch i_as and i_bs sign-extended to DW+CW+1, clear acc and cnt, go to CALC.
- CALC:
  - o_ready=0, o_busy=1.
  - Each cycle with k=cnt: acc ← acc + (CA[k] ? a<<k : 0) − (CB[k] ? b<<k : 0); then cnt ← cnt+1.
  - After the update at k=CW−1, go to DONE.
  - i_valid and operand inputs are ignored. Input changes after acceptance never affect the result.
- DONE:
  - o_valid=1, o_ready=0.
  - When i_ready=1, go to IDLE.
  - o_fs and o_valid hold stable while i_ready=0, for any number of cycles.
- o_fs:
  - Driven from acc, registered.
  - Equals the final result whenever o_valid=1.
  - Holds its last value in IDLE and CALC.
- Arithmetic:
  - All internal math is signed at DW+CW+1 bits. The result range is provably within it, so overflow cannot occur.
  - Default range is −261 (a=−16, b=15) to +266 (a=15, b=−16), 10 bits.
- Coefficient bits equal to 0 still take a cycle; CALC length is always CW cycles.

## Timing
- Acceptance edge: i_valid & o_ready at edge E0.
- CALC occupies the edges after E0 up to E0+CW. o_valid=1 from edge E0+CW, i.e. latency CW cycles.
- Result handshake: completes at the first edge where o_valid & i_ready.
- Without the pass-through macro (see Configuration):
  - the block returns to IDLE at that edge;
  - the next accept is possible one edge later;
  - minimum initiation interval is CW+2 cycles.
- Reset mid-operation (any state): immediate return to IDLE with reset values. The in-flight result is discarded and no o_valid is produced for it.
- i_valid asserted while o_ready=0 is not a transfer. The producer must hold its data.

## Configuration
- SIGNED_CALC_SEQ_PASS_EN defined:
  - In DONE, o_ready = i_ready.
  - If i_valid & i_ready in DONE, the result retires and new operands are latched on the same edge, going directly to CALC with acc and cnt cleared.
  - Initiation interval becomes CW+1 cycles.
- SIGNED_CALC_SEQ_PASS_EN undefined: o_ready=0 in DONE; behaviour exactly as in Operation.

## Test plan
- Reset, then a=3, b=2, i_ready=1 → o_valid at accept+4 cycles, o_fs=−4, one cycle wide. o_ready is 1 after reset.
- a=15, b=−16 → o_fs=+266. a=−16, b=15 → o_fs=−261, all DW+CW+1 bits correct.
- Hold i_ready=0 for 7 cycles after o_valid with a=−5, b=−7 (expect 47) → o_fs=47 and o_valid stay stable. Toggling i_as and i_valid during CALC/DONE has no effect.
- Assert i_rst at the 2nd CALC cycle of a=7, b=1 → outputs return to reset values immediately. No o_valid follows. The next transaction a=1, b=1 gives −5.
- Stream a=1..4, b=0 with i_valid and i_ready held high → results 6, 12, 18, 24 in order. Interval is 6 cycles with the macro undefined, 5 cycles with SIGNED_CALC_SEQ_PASS_EN.
- Random 1000 operand pairs with random i_ready stalls → every o_fs equals 6a−11b; results are in order, with no loss or duplication.
